ccip_mem_responder: RTL and testbench
=====================================

Name: ccip_mem_responder

Overview:
- Synthesizable memory-side responder for the CCI-P request channels driven by afu_io: consumes c0 read requests and c1 write requests, and returns c0 read responses and c1 write responses with a fixed, configurable latency.
- Backed by an on-chip 512-bit-wide RAM.
- Used as the host-memory end in loopback test builds and in full-AFU simulation, in place of the platform shell.

Parameters:
MEM_AW, 10, RAM word-address width; 2^MEM_AW cache lines.
RD_FIFO_DEPTH, 16, read-request FIFO depth; power of two.
AF_SLACK, 4, free entries remaining when almostfull asserts.
RD_LATENCY, 4, cycles from request accepted to response valid, FIFO empty; minimum 2.

Ports:
clk  in  1  single clock.
spl_reset  in  1  reset; synchronous, active-high.
afu_tx_rd_valid  in  1  read request strobe.
afu_tx_rd_addr  in  42  cache-line read address.
afu_tx_rd_mdata  in  16  read tag, echoed in the response.
spl_tx_rd_almostfull  out  1  read back-pressure.
spl_rx_rd_valid  out  1  read response strobe.
spl_rx_rd_mdata  out  16  echoed read tag.
spl_rx_data  out  512  read data.
afu_tx_wr_valid  in  1  write request strobe.
afu_tx_wr_addr  in  42  cache-line write address.
afu_tx_wr_mdata  in  16  write tag.
afu_tx_data  in  512  write data.
spl_tx_wr_almostfull  out  1  write back-pressure.
spl_rx_wr_valid  out  1  write response strobe.
spl_rx_wr_mdata  out  16  echoed write tag.
rd_overflow  out  1  sticky: a read request was dropped.

Behaviour:
- Reset: applies on the clk edge while spl_reset=1.
  - Clears FIFO pointers and count, all delay-line valid bits, spl_rx_rd_valid, spl_rx_wr_valid and rd_overflow.
  - Clears spl_rx_rd_mdata and spl_rx_data to 0.
  - Drives spl_tx_rd_almostfull=1 and spl_tx_wr_almostfull=1 during reset and for 1 cycle after deassertion.
  - RAM contents are not cleared.
- Addressing: only addr[MEM_AW-1:0] is used; upper bits are ignored, so out-of-range addresses alias/wrap.
- Read request FIFO:
  - Push on afu_tx_rd_valid when count < RD_FIFO_DEPTH.
  - Push while full: the request is dropped, rd_overflow sets and stays set until reset.
  - Pop one entry per cycle whenever non-empty; no downstream stall exists.
  - Push and pop in the same cycle: count unchanged; a push into an empty FIFO is not popped until the next cycle.
  - spl_tx_rd_almostfull is registered and equals (count >= RD_FIFO_DEPTH-AF_SLACK).
- Read pipeline:
  - Popped entry issues a synchronous RAM read (1 cycle).
  - Data and mdata then pass through a delay line of RD_LATENCY-2 stages, then the output register.
  - Total latency with an empty FIFO: request at cycle T gives spl_rx_rd_valid at T+RD_LATENCY.
  - Responses are in order; sustained throughput is 1 per cycle.
  - spl_rx_data and spl_rx_rd_mdata hold their last value while valid=0.
- Writes:
  - afu_tx_wr_valid at T writes the RAM at T.
  - spl_rx_wr_valid=1 with spl_rx_wr_mdata at T+1.
  - No queue, 1 write per cycle; spl_tx_wr_almostfull is 0 outside the reset window.
  - Writes arriving during the reset window are ignored.
- Read/write ordering: a RAM read issued in the same cycle as a write to the same line returns the old data. A write at T is visible to reads issued at T+1 or later.
- Read and write response channels are independent; both may assert in the same cycle.
- Reset mid-operation: all in-flight reads and the pending write response are discarded, with no response issued. A write that landed before the reset edge persists.
- Protocol violation: requests presented while almostfull=1 are still accepted if space exists. almostfull is advisory.

Test Plan:
- Write line 5 = {16{32'hA5A5_0000+i}}, mdata 16'h0011 → spl_rx_wr_valid at +1 with mdata 0011. Then read line 5, mdata 16'h0022 → spl_rx_rd_valid exactly 4 cycles later with the same data, mdata 0022.
- 16 back-to-back reads, mdata 0..15, addresses 0..15 preloaded with the address value → 16 consecutive in-order responses starting at +4, each data==addr. almostfull never asserts.
- Hold the FIFO non-draining by bursting 20 reads in 1 cycle each at a reduced-depth config (RD_FIFO_DEPTH=4, AF_SLACK=1, stall injected via a parameterized test hook) → almostfull at count 3; 5th push while full dropped; rd_overflow=1 and stays 1.
- Same-cycle write line 7 = X and pop of a read to line 7 (old Y) → read returns Y. Next read of line 7 returns X.
- Read to address 42'h1_0000_0405 with MEM_AW=10 → returns data of line 0x005.
- Assert spl_reset for 1 cycle while 3 reads are in flight → no further spl_rx_rd_valid. Both almostfull signals are high for the reset cycle plus 1 cycle. rd_overflow is cleared. Line 5 data is retained.

Source files
------------

// File: rtl/ccip_mem_responder.sv
// ---------------------------------------------------------------------------
// ccip_mem_responder
//
// Memory-side responder for the CCI-P request channels. Stands in for the
// platform shell in loopback and full-AFU simulation builds: read requests
// on c0 are queued, looked up in an on-chip 512-bit RAM and returned in order
// with a fixed latency; write requests on c1 update the RAM immediately and
// are acknowledged one cycle later.
//
// Handshake semantics (all channels): a request is a single-cycle strobe,
// there is no ready signal. almostfull is advisory back-pressure only; a read
// request is taken whenever the queue has room, even with almostfull high,
// and is dropped (rd_overflow set, sticky) when the queue is full. Responses
// are single-cycle strobes with no stall from the receiver.
//
// Ports:
//   clk, spl_reset              clock, synchronous active-high reset
//   afu_tx_rd_valid/addr/mdata  read request (cache-line address, tag)
//   spl_tx_rd_almostfull        read back-pressure (registered)
//   spl_rx_rd_valid/mdata       read response strobe and echoed tag
//   spl_rx_data                 read response data
//   afu_tx_wr_valid/addr/mdata  write request (cache-line address, tag)
//   afu_tx_data                 write data
//   spl_tx_wr_almostfull        write back-pressure (only around reset)
//   spl_rx_wr_valid/mdata       write response strobe and echoed tag
//   rd_overflow                 sticky: a read request was dropped
//
// TEST_STALL_POP freezes the read queue (no pops) so a bench can fill it.
// ---------------------------------------------------------------------------
module ccip_mem_responder #(
  parameter int MEM_AW         = 10,
  parameter int RD_FIFO_DEPTH  = 16,
  parameter int AF_SLACK       = 4,
  parameter int RD_LATENCY     = 4,
  parameter bit TEST_STALL_POP = 1'b0
) (
  input  logic         clk,
  input  logic         spl_reset,
  input  logic         afu_tx_rd_valid,
  input  logic [41:0]  afu_tx_rd_addr,
  input  logic [15:0]  afu_tx_rd_mdata,
  output logic         spl_tx_rd_almostfull,
  output logic         spl_rx_rd_valid,
  output logic [15:0]  spl_rx_rd_mdata,
  output logic [511:0] spl_rx_data,
  input  logic         afu_tx_wr_valid,
  input  logic [41:0]  afu_tx_wr_addr,
  input  logic [15:0]  afu_tx_wr_mdata,
  input  logic [511:0] afu_tx_data,
  output logic         spl_tx_wr_almostfull,
  output logic         spl_rx_wr_valid,
  output logic [15:0]  spl_rx_wr_mdata,
  output logic         rd_overflow
);

  localparam int PW = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int DL = RD_LATENCY - 2;   // delay stages between RAM and output
  localparam logic [CW-1:0] DEPTH_C = CW'(RD_FIFO_DEPTH);
  localparam logic [CW-1:0] AF_THR  = CW'(RD_FIFO_DEPTH - AF_SLACK);

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [511:0]      mem [2**MEM_AW];
  logic [MEM_AW-1:0] fifo_addr_q  [RD_FIFO_DEPTH];
  logic [15:0]       fifo_mdata_q [RD_FIFO_DEPTH];

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          rst_hold_q;       // high for the first cycle after reset
  logic          rd_af_q, wr_af_q;
  logic          overflow_q;
  logic          wr_rsp_valid_q;
  logic [15:0]   wr_rsp_mdata_q;

  // RAM read stage
  logic          ram_valid_q;
  logic [15:0]   ram_mdata_q;
  logic [511:0]  ram_data_q;

  // Tail of the delay line feeding the output register
  logic          last_valid;
  logic [15:0]   last_mdata;
  logic [511:0]  last_data;

  // Output register
  logic          out_valid_q;
  logic [15:0]   out_mdata_q;
  logic [511:0]  out_data_q;

  logic push, pop, wr_accept;
  logic [MEM_AW-1:0] wr_idx, rd_idx;

  // Upper address bits are deliberately ignored; lines alias modulo 2^MEM_AW.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{afu_tx_rd_addr[41:MEM_AW], afu_tx_wr_addr[41:MEM_AW]};

  assign wr_idx = afu_tx_wr_addr[MEM_AW-1:0];
  assign rd_idx = afu_tx_rd_addr[MEM_AW-1:0];

  always_comb begin
    // Pop decision uses the pre-edge count, so an entry pushed into an empty
    // queue is popped on the following edge at the earliest.
    push      = afu_tx_rd_valid && (count_q != DEPTH_C);
    pop       = (count_q != '0) && !TEST_STALL_POP;
    // Writes in the reset cycle and the cycle after it are ignored.
    wr_accept = afu_tx_wr_valid && !spl_reset && !rst_hold_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Queue pointers, flags, write response, RAM-stage valid
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (spl_reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      rst_hold_q     <= 1'b1;
      rd_af_q        <= 1'b1;
      wr_af_q        <= 1'b1;
      ram_valid_q    <= 1'b0;
      wr_rsp_valid_q <= 1'b0;
      wr_rsp_mdata_q <= '0;
    end else begin
      rst_hold_q <= 1'b0;
      // Stretch both almostfull flags over the first post-reset cycle.
      rd_af_q    <= rst_hold_q || (count_d >= AF_THR);
      wr_af_q    <= rst_hold_q;
      count_q    <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (afu_tx_rd_valid && !push) begin
        overflow_q <= 1'b1;
      end
      ram_valid_q    <= pop;
      wr_rsp_valid_q <= wr_accept;
      if (wr_accept) begin
        wr_rsp_mdata_q <= afu_tx_wr_mdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Queue storage (no reset needed: entries are qualified by count)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= rd_idx;
      fifo_mdata_q[wr_ptr_q] <= afu_tx_rd_mdata;
    end
  end

  // ---------------------------------------------------------------------
  // RAM: write and synchronous read in one block. The read samples the old
  // contents when it hits the line being written on the same edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_idx] <= afu_tx_data;
    end
    if (pop) begin
      ram_data_q  <= mem[fifo_addr_q[rd_ptr_q]];
      ram_mdata_q <= fifo_mdata_q[rd_ptr_q];
    end
  end

  // ---------------------------------------------------------------------
  // Delay line: RD_LATENCY-2 stages between the RAM read and the output.
  // ---------------------------------------------------------------------
  if (DL > 0) begin : g_delay
    logic         dl_valid_q [DL];
    logic [15:0]  dl_mdata_q [DL];
    logic [511:0] dl_data_q  [DL];

    always_ff @(posedge clk) begin
      if (spl_reset) begin
        for (int i = 0; i < DL; i++) begin
          dl_valid_q[i] <= 1'b0;
        end
      end else begin
        dl_valid_q[0] <= ram_valid_q;
        for (int i = 1; i < DL; i++) begin
          dl_valid_q[i] <= dl_valid_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      dl_mdata_q[0] <= ram_mdata_q;
      dl_data_q[0]  <= ram_data_q;
      for (int i = 1; i < DL; i++) begin
        dl_mdata_q[i] <= dl_mdata_q[i-1];
        dl_data_q[i]  <= dl_data_q[i-1];
      end
    end

    assign last_valid = dl_valid_q[DL-1];
    assign last_mdata = dl_mdata_q[DL-1];
    assign last_data  = dl_data_q[DL-1];
  end else begin : g_no_delay
    assign last_valid = ram_valid_q;
    assign last_mdata = ram_mdata_q;
    assign last_data  = ram_data_q;
  end

  // ---------------------------------------------------------------------
  // Output register: data and tag hold their last value while valid is low.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (spl_reset) begin
      out_valid_q <= 1'b0;
      out_mdata_q <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= last_valid;
      if (last_valid) begin
        out_mdata_q <= last_mdata;
        out_data_q  <= last_data;
      end
    end
  end

  assign spl_tx_rd_almostfull = rd_af_q;
  assign spl_tx_wr_almostfull = wr_af_q;
  assign spl_rx_rd_valid      = out_valid_q;
  assign spl_rx_rd_mdata      = out_mdata_q;
  assign spl_rx_data          = out_data_q;
  assign spl_rx_wr_valid      = wr_rsp_valid_q;
  assign spl_rx_wr_mdata      = wr_rsp_mdata_q;
  assign rd_overflow          = overflow_q;

endmodule

// File: tb/tb_ccip_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_ccip_mem_responder
//
// Two instances: the default configuration, and a depth-4 queue with pops
// frozen so fill/almostfull/overflow can be observed. A queue-based reference
// model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_ccip_mem_responder;

  localparam int MEM_AW     = 10;
  localparam int DEPTH      = 16;
  localparam int SLACK      = 4;
  localparam int LAT        = 4;
  localparam int S_DEPTH    = 4;
  localparam int S_SLACK    = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         spl_reset;
  logic         rd_valid, wr_valid;
  logic [41:0]  rd_addr, wr_addr;
  logic [15:0]  rd_mdata, wr_mdata;
  logic [511:0] wr_data;

  logic         rd_af, rsp_rd_valid, wr_af, rsp_wr_valid, ovf;
  logic [15:0]  rsp_rd_mdata, rsp_wr_mdata;
  logic [511:0] rsp_data;

  logic         s_rd_valid;
  logic         s_rd_af, s_rsp_rd_valid, s_wr_af, s_rsp_wr_valid, s_ovf;
  logic [15:0]  s_rsp_rd_mdata, s_rsp_wr_mdata;
  logic [511:0] s_rsp_data;

  ccip_mem_responder #(
    .MEM_AW(MEM_AW), .RD_FIFO_DEPTH(DEPTH), .AF_SLACK(SLACK),
    .RD_LATENCY(LAT), .TEST_STALL_POP(1'b0)
  ) dut (
    .clk(clk), .spl_reset(spl_reset),
    .afu_tx_rd_valid(rd_valid), .afu_tx_rd_addr(rd_addr), .afu_tx_rd_mdata(rd_mdata),
    .spl_tx_rd_almostfull(rd_af), .spl_rx_rd_valid(rsp_rd_valid),
    .spl_rx_rd_mdata(rsp_rd_mdata), .spl_rx_data(rsp_data),
    .afu_tx_wr_valid(wr_valid), .afu_tx_wr_addr(wr_addr), .afu_tx_wr_mdata(wr_mdata),
    .afu_tx_data(wr_data), .spl_tx_wr_almostfull(wr_af),
    .spl_rx_wr_valid(rsp_wr_valid), .spl_rx_wr_mdata(rsp_wr_mdata),
    .rd_overflow(ovf)
  );

  ccip_mem_responder #(
    .MEM_AW(MEM_AW), .RD_FIFO_DEPTH(S_DEPTH), .AF_SLACK(S_SLACK),
    .RD_LATENCY(LAT), .TEST_STALL_POP(1'b1)
  ) dut_s (
    .clk(clk), .spl_reset(spl_reset),
    .afu_tx_rd_valid(s_rd_valid), .afu_tx_rd_addr(42'd3), .afu_tx_rd_mdata(16'h0bad),
    .spl_tx_rd_almostfull(s_rd_af), .spl_rx_rd_valid(s_rsp_rd_valid),
    .spl_rx_rd_mdata(s_rsp_rd_mdata), .spl_rx_data(s_rsp_data),
    .afu_tx_wr_valid(1'b0), .afu_tx_wr_addr(42'd0), .afu_tx_wr_mdata(16'd0),
    .afu_tx_data(512'd0), .spl_tx_wr_almostfull(s_wr_af),
    .spl_rx_wr_valid(s_rsp_wr_valid), .spl_rx_wr_mdata(s_rsp_wr_mdata),
    .rd_overflow(s_ovf)
  );

  // ---------------- scoreboard / check ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [MEM_AW-1:0] a; logic [15:0] m; } rq_t;
  typedef struct { int due; logic [15:0] m; logic [511:0] d; } fl_t;

  logic [511:0] mmem [2**MEM_AW];
  rq_t          rq[$];       // pending read requests
  fl_t          fl[$];       // reads in flight, with the cycle they appear
  logic [511:0] exp_q[$];    // data of responses seen, for the final report
  int           cyc = 0;
  bit           model_on = 0;
  bit           hold = 0;
  bit           e_rd_v, e_wr_v, e_rd_af, e_wr_af, e_ovf;
  logic [15:0]  e_rd_m, e_wr_m;
  logic [511:0] e_rd_d;
  int           s_n;
  bit           s_ovf_e, s_af_e;

  task automatic model_update();
    rq_t q;
    fl_t f;
    int  pre;
    bit  h;
    cyc++;
    h = hold;
    if (spl_reset) begin
      model_on = 1;
      rq.delete();
      fl.delete();
      hold = 1;
      e_ovf = 0; e_rd_af = 1; e_wr_af = 1;
      e_rd_v = 0; e_rd_m = '0; e_rd_d = '0; e_wr_v = 0;
      s_n = 0; s_ovf_e = 0; s_af_e = 1;
    end else begin
      e_rd_v = 0;
      if (fl.size() > 0 && fl[0].due == cyc) begin
        f = fl.pop_front();
        e_rd_v = 1; e_rd_m = f.m; e_rd_d = f.d;
        exp_q.push_back(f.d);
      end
      pre = rq.size();
      if (pre > 0) begin
        q = rq.pop_front();
        f.due = cyc + LAT - 1; f.m = q.m; f.d = mmem[q.a];
        fl.push_back(f);
      end
      if (rd_valid) begin
        if (pre < DEPTH) begin
          q.a = rd_addr[MEM_AW-1:0]; q.m = rd_mdata;
          rq.push_back(q);
        end else begin
          e_ovf = 1;
        end
      end
      e_wr_v = wr_valid && !h;
      if (e_wr_v) begin
        mmem[wr_addr[MEM_AW-1:0]] = wr_data;
        e_wr_m = wr_mdata;
      end
      e_wr_af = h;
      e_rd_af = h || (rq.size() >= DEPTH - SLACK);
      if (s_rd_valid) begin
        if (s_n < S_DEPTH) s_n++;
        else s_ovf_e = 1;
      end
      s_af_e = h || (s_n >= S_DEPTH - S_SLACK);
      hold = 0;
    end
  endtask

  task automatic compare_all();
    check("rd_valid", rsp_rd_valid, e_rd_v);
    check("rd_mdata", rsp_rd_mdata, e_rd_m);
    check("rd_data", rsp_data, e_rd_d);
    check("wr_valid", rsp_wr_valid, e_wr_v);
    if (e_wr_v) check("wr_mdata", rsp_wr_mdata, e_wr_m);
    check("rd_af", rd_af, e_rd_af);
    check("wr_af", wr_af, e_wr_af);
    check("rd_overflow", ovf, e_ovf);
    check("s_rd_af", s_rd_af, s_af_e);
    check("s_rd_overflow", s_ovf, s_ovf_e);
    check("s_rd_valid", s_rsp_rd_valid, 1'b0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (model_on) compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input logic [41:0] a, input logic [511:0] d, input logic [15:0] m);
    wr_valid = 1; wr_addr = a; wr_data = d; wr_mdata = m;
    step();
    wr_valid = 0;
  endtask

  task automatic do_read(input logic [41:0] a, input logic [15:0] m);
    rd_valid = 1; rd_addr = a; rd_mdata = m;
    step();
    rd_valid = 0;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [41:0] rand_addr(input int line);
    logic [41:0] a;
    a = 42'({$urandom, $urandom});
    a[MEM_AW-1:0] = MEM_AW'(line);
    return a;
  endfunction

  // ---------------- stimulus ----------------
  logic [511:0] pat;

  initial begin
    spl_reset = 1; rd_valid = 0; wr_valid = 0; s_rd_valid = 0;
    rd_addr = '0; wr_addr = '0; rd_mdata = '0; wr_mdata = '0; wr_data = '0;
    idle(3);
    spl_reset = 0;
    idle(2);

    // Write then read line 5
    for (int i = 0; i < 16; i++) pat[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    do_write(42'd5, pat, 16'h0011);
    idle(1);
    do_read(42'd5, 16'h0022);
    idle(6);

    // Preload lines 0..15 with their address, 16..31 random
    for (int i = 0; i < 16; i++) do_write(42'(i), 512'(i), 16'(i));
    for (int i = 16; i < 32; i++) do_write(42'(i), rand_line(), 16'(i));
    idle(1);

    // 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1; rd_addr = 42'(i); rd_mdata = 16'(i);
      step();
    end
    rd_valid = 0;
    idle(8);

    // Same-edge write/read of line 7
    do_write(42'd7, rand_line(), 16'h0070);
    do_read(42'd7, 16'h0071);
    rd_valid = 1; rd_addr = 42'd7; rd_mdata = 16'h0072;
    wr_valid = 1; wr_addr = 42'd7; wr_data = rand_line(); wr_mdata = 16'h0073;
    step();
    rd_valid = 0; wr_valid = 0;
    idle(6);

    // Aliased address
    do_write(42'd5, pat, 16'h0012);
    do_read(42'h1_0000_0405, 16'h0405);
    idle(6);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rd_valid = ($urandom_range(0, 99) < 60);
      rd_addr  = rand_addr($urandom_range(0, 31));
      rd_mdata = 16'($urandom);
      wr_valid = ($urandom_range(0, 99) < 35);
      wr_addr  = rand_addr($urandom_range(16, 31));
      wr_mdata = 16'($urandom);
      wr_data  = rand_line();
      step();
    end
    rd_valid = 0; wr_valid = 0;
    idle(6);

    // Fill the frozen queue: 20 back-to-back pushes
    for (int k = 0; k < 20; k++) begin
      s_rd_valid = 1;
      step();
    end
    s_rd_valid = 0;
    idle(3);
    check("s_ovf_sticky", s_ovf, 1'b1);

    // Reset with three reads in flight and a write during reset
    for (int i = 0; i < 3; i++) do_read(42'(i), 16'(16'h0100 + i));
    spl_reset = 1;
    wr_valid = 1; wr_addr = 42'd5; wr_data = rand_line(); wr_mdata = 16'hdead;
    step();
    spl_reset = 0; wr_valid = 0;
    check("s_ovf_cleared", s_ovf, 1'b0);
    idle(8);
    do_read(42'd5, 16'h0555);
    idle(6);
    check("line5_retained", rsp_data, pat);
    check("responses_seen", 512'(exp_q.size()) != 512'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
